// File: rtl/k580vt57_pkg.sv
// Shared types and constants for the K580VT57 four-channel DMA controller.
package k580vt57_pkg;

  typedef enum logic [2:0] {IDLE, HREQ, S1, S2, S3, S4} state_t;

  localparam logic [3:0] REG_MODE    = 4'd8;
  localparam int         MB_ROT      = 4;
  localparam int         MB_TCSTOP   = 6;
  localparam int         MB_AUTOLOAD = 7;

  localparam logic [1:0] XM_VERIFY = 2'b00;
  localparam logic [1:0] XM_WRITE  = 2'b01;
  localparam logic [1:0] XM_READ   = 2'b10;

  // First requesting channel found when scanning upward (with wrap) from 'first'.
  function automatic logic [1:0] pick_ch(input logic [3:0] req, input logic [1:0] first);
    logic [1:0] c;
    logic [1:0] r;
    logic       found;
    r     = first;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = first + 2'(i);
      if (!found && req[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/k580vt57_channel.sv
// One DMA channel: address/count registers with byte-wise CPU load, per-transfer step and reload.
module k580vt57_channel (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_wr_addr,
  input  logic        i_wr_cnt,
  input  logic        i_hi,
  input  logic [7:0]  i_data,
  input  logic        i_step,
  input  logic        i_reload,
  input  logic [15:0] i_rl_addr,
  input  logic [15:0] i_rl_cnt,
  output logic [15:0] o_addr,
  output logic [15:0] o_cnt,
  output logic        o_tc
);

  logic [15:0] r_addr;
  logic [15:0] r_cnt;

  // A CPU byte write beats a same-cycle reload or step on that register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= 16'h0000;
      r_cnt  <= 16'h0000;
    end else begin
      if (i_wr_addr)
        r_addr <= i_hi ? {i_data, r_addr[7:0]} : {r_addr[15:8], i_data};
      else if (i_reload)
        r_addr <= i_rl_addr;
      else if (i_step)
        r_addr <= r_addr + 16'd1;

      if (i_wr_cnt)
        r_cnt <= i_hi ? {i_data, r_cnt[7:0]} : {r_cnt[15:8], i_data};
      else if (i_reload)
        r_cnt <= i_rl_cnt;
      else if (i_step)
        r_cnt <= {r_cnt[15:14], r_cnt[13:0] - 14'd1};
    end
  end

  assign o_addr = r_addr;
  assign o_cnt  = r_cnt;
  assign o_tc   = (r_cnt[13:0] == 14'd0);

endmodule

// File: rtl/k580vt57.sv
// K580VT57 DMA controller top: CPU register interface, channel arbiter and S1..S4 transfer FSM.
module k580vt57
  import k580vt57_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int AUTOLOAD_CH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic [3:0]  drq,
  output logic [3:0]  dack,
  output logic        hrq,
  input  logic        hlda,
  output logic [15:0] oaddr,
  output logic        memr_n,
  output logic        memw_n,
  output logic        tc
);

  localparam logic [1:0] LC_AL = 2'(AUTOLOAD_CH);

  state_t          r_state, w_next;
  logic            r_we_q, r_rd_q, r_bff, r_upd;
  logic [7:0]      r_mode;
  logic [NCH-1:0]  r_tcf;
  logic [1:0]      r_ch, r_last;
  logic [15:0]     w_addr [NCH];
  logic [15:0]     w_cnt  [NCH];
  logic [15:0]     w_word;
  logic [NCH-1:0]  w_tcd, w_wr_addr, w_wr_cnt, w_step, w_reload, w_req;
  logic            w_wr, w_rd, w_is_mode, w_is_chan, w_autoload, w_cur_tc, w_in_s3, w_grant;
  logic [1:0]      w_first, w_win, w_cur_mode;

  // Strobes act on their rising edge, seen one clock after the pin returns high.
  assign w_wr       = iwe_n & ~r_we_q;
  assign w_rd       = ird_n & ~r_rd_q;
  assign w_is_mode  = (iaddr == REG_MODE);
  assign w_is_chan  = ~iaddr[3];
  assign w_autoload = r_mode[MB_AUTOLOAD];
  assign w_req      = drq & r_mode[NCH-1:0];
  assign w_first    = r_mode[MB_ROT] ? r_last + 2'd1 : 2'd0;
  assign w_win      = pick_ch(w_req, w_first);
  assign w_cur_tc   = w_tcd[r_ch];
  assign w_cur_mode = w_cnt[r_ch][15:14];
  assign w_in_s3    = (r_state == S3);
  assign w_grant    = ((r_state == HREQ) || (r_state == S4)) && (w_next == S1);

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic w_sel;
    assign w_sel = (iaddr[2:1] == 2'(n)) ||
                   (w_autoload && (n == AUTOLOAD_CH + 1) && (iaddr[2:1] == LC_AL));
    assign w_wr_addr[n] = w_wr & w_is_chan & ~iaddr[0] & w_sel;
    assign w_wr_cnt[n]  = w_wr & w_is_chan &  iaddr[0] & w_sel;
    assign w_step[n]    = w_in_s3 & (r_ch == 2'(n));
    assign w_reload[n]  = w_step[n] & w_cur_tc & w_autoload & (n == AUTOLOAD_CH);

    k580vt57_channel u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_wr_addr (w_wr_addr[n]),
      .i_wr_cnt  (w_wr_cnt[n]),
      .i_hi      (r_bff),
      .i_data    (idata),
      .i_step    (w_step[n]),
      .i_reload  (w_reload[n]),
      .i_rl_addr (w_addr[AUTOLOAD_CH+1]),
      .i_rl_cnt  (w_cnt[AUTOLOAD_CH+1]),
      .o_addr    (w_addr[n]),
      .o_cnt     (w_cnt[n]),
      .o_tc      (w_tcd[n])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    hrq    = 1'b0;
    dack   = 4'b0000;
    oaddr  = 16'h0000;
    memr_n = 1'b1;
    memw_n = 1'b1;
    tc     = 1'b0;
    case (r_state)
      IDLE: if (|w_req) w_next = HREQ;
      HREQ: begin
        hrq = 1'b1;
        if (!(|w_req))  w_next = IDLE;
        else if (hlda)  w_next = S1;
      end
      S1, S2, S3: begin
        hrq   = 1'b1;
        dack  = 4'b0001 << r_ch;
        oaddr = w_addr[r_ch];
        tc    = w_cur_tc;
        if (r_state == S2) begin
          memr_n = (w_cur_mode != XM_READ);
          memw_n = (w_cur_mode != XM_WRITE);
        end
        w_next = (r_state == S1) ? S2 : (r_state == S2) ? S3 : S4;
      end
      S4: begin
        hrq    = 1'b1;
        w_next = ((|w_req) && hlda) ? S1 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we_q <= 1'b1;
      r_rd_q <= 1'b1;
      r_ch   <= 2'd0;
      r_last <= 2'(NCH - 1);
      r_mode <= 8'h00;
      r_bff  <= 1'b0;
      r_tcf  <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_we_q <= iwe_n;
      r_rd_q <= ird_n;
      if (w_grant) begin
        r_ch   <= w_win;
        r_last <= w_win;
      end
      // The autoloaded video channel stays enabled through its terminal count.
      if (w_wr && w_is_mode)
        r_mode <= idata;
      else if (w_in_s3 && w_cur_tc && r_mode[MB_TCSTOP] && !(w_autoload && r_ch == LC_AL))
        r_mode[r_ch] <= 1'b0;
      if (w_wr && w_is_mode)
        r_bff <= 1'b0;
      else if ((w_wr || w_rd) && w_is_chan)
        r_bff <= ~r_bff;
      r_tcf <= ((w_rd && w_is_mode) ? '0 : r_tcf) | ({NCH{w_cur_tc}} & w_step);
      if (w_in_s3 && r_ch == LC_AL) begin
        if (w_cur_tc && w_autoload) r_upd <= 1'b1;
        else if (!w_cur_tc)         r_upd <= 1'b0;
      end
    end
  end

  always_comb begin
    w_word = iaddr[0] ? w_cnt[iaddr[2:1]] : w_addr[iaddr[2:1]];
    odata  = 8'h00;
    if (w_is_mode)      odata = {3'b000, r_upd, r_tcf};
    else if (w_is_chan) odata = r_bff ? w_word[15:8] : w_word[7:0];
  end

endmodule

// File: tb/tb_k580vt57.sv
// Self-checking bench for k580vt57 with a transaction-level register/transfer model.
module tb_k580vt57;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  iaddr = 4'd0;
  logic [7:0]  idata = 8'h00;
  logic [7:0]  odata;
  logic        iwe_n = 1'b1;
  logic        ird_n = 1'b1;
  logic [3:0]  drq = 4'b0000;
  logic [3:0]  dack;
  logic        hrq;
  logic        hlda = 1'b0;
  logic        hlda_en = 1'b0;
  logic [15:0] oaddr;
  logic        memr_n, memw_n, tc;

  k580vt57 dut (
    .clk(clk), .reset_n(reset_n), .iaddr(iaddr), .idata(idata), .odata(odata),
    .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
    .oaddr(oaddr), .memr_n(memr_n), .memw_n(memw_n), .tc(tc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) hlda <= hlda_en & hrq;

  int n_chk = 0;
  int n_err = 0;
  int ntr, rd_low, wr_low;
  int chn [4];

  logic [15:0] m_addr [4];
  logic [15:0] m_cnt  [4];
  logic [7:0]  m_mode;
  logic [3:0]  m_tcf;
  logic        m_upd, m_bff;
  int          m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin m_addr[i] = 0; m_cnt[i] = 0; end
    m_mode = 0; m_tcf = 0; m_upd = 0; m_bff = 0; m_last = 3;
  endtask

  task automatic m_write(input logic [3:0] a, input logic [7:0] d);
    int ch;
    if (a == 4'd8) begin
      m_mode = d; m_bff = 0;
    end else if (a < 4'd8) begin
      ch = int'(a[2:1]);
      for (int k = 0; k < 4; k++) begin
        if (k == ch || (k == 3 && ch == 2 && m_mode[7])) begin
          if (a[0]) begin
            if (m_bff) m_cnt[k][15:8] = d; else m_cnt[k][7:0] = d;
          end else begin
            if (m_bff) m_addr[k][15:8] = d; else m_addr[k][7:0] = d;
          end
        end
      end
      m_bff = ~m_bff;
    end
  endtask

  task automatic m_read(input logic [3:0] a, output logic [7:0] d);
    logic [15:0] w;
    d = 8'h00;
    if (a == 4'd8) begin
      d = {3'b000, m_upd, m_tcf};
      m_tcf = 0;
    end else if (a < 4'd8) begin
      w = a[0] ? m_cnt[a[2:1]] : m_addr[a[2:1]];
      d = m_bff ? w[15:8] : w[7:0];
      m_bff = ~m_bff;
    end
  endtask

  function automatic int m_next_ch();
    logic [3:0] req;
    int base;
    req  = drq & m_mode[3:0];
    base = m_mode[4] ? m_last + 1 : 0;
    for (int k = 0; k < 4; k++)
      if (req[(base + k) % 4]) return (base + k) % 4;
    return 0;
  endfunction

  task automatic m_transfer(input int ch);
    logic tcz;
    tcz = (m_cnt[ch][13:0] == 14'd0);
    m_addr[ch] = m_addr[ch] + 16'd1;
    m_cnt[ch][13:0] = m_cnt[ch][13:0] - 14'd1;
    m_last = ch;
    if (tcz) begin
      m_tcf[ch] = 1'b1;
      if (m_mode[7] && ch == 2) begin
        m_addr[2] = m_addr[3]; m_cnt[2] = m_cnt[3]; m_upd = 1'b1;
      end else if (m_mode[6]) begin
        m_mode[ch] = 1'b0;
      end
    end else if (ch == 2) begin
      m_upd = 1'b0;
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); iaddr = a; idata = d; iwe_n = 1'b0;
    @(negedge clk); iwe_n = 1'b1;
    @(negedge clk);
    m_write(a, d);
  endtask

  task automatic cpu_rd_chk(input logic [3:0] a, input string tag);
    logic [7:0] e;
    @(negedge clk); iaddr = a; ird_n = 1'b0;
    @(negedge clk);
    m_read(a, e);
    chk(tag, odata, e);
    ird_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic prog_ch(input int ch, input logic [15:0] a, input logic [15:0] c);
    cpu_wr(4'(2 * ch), a[7:0]);     cpu_wr(4'(2 * ch), a[15:8]);
    cpu_wr(4'(2 * ch + 1), c[7:0]); cpu_wr(4'(2 * ch + 1), c[15:8]);
  endtask

  // Monitors transfers; drops drq at the start of transfer number stop_after.
  task automatic run(input int stop_after, input string tag);
    logic [3:0] pd;
    logic       pend, done;
    logic [1:0] pmode;
    int         ech;
    ntr = 0; rd_low = 0; wr_low = 0; pd = 0; pend = 0; done = 0; pmode = 0;
    for (int i = 0; i < 4; i++) chn[i] = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (!memr_n) rd_low++;
      if (!memw_n) wr_low++;
      if (pend) begin
        chk({tag, "_memr"}, memr_n, (pmode == 2'b10) ? 1'b0 : 1'b1);
        chk({tag, "_memw"}, memw_n, (pmode == 2'b01) ? 1'b0 : 1'b1);
        pend = 0;
      end
      if (dack != 0 && pd == 0) begin
        ech = m_next_ch();
        chk({tag, "_dack"}, dack, 32'(1) << ech);
        chk({tag, "_oaddr"}, oaddr, m_addr[ech]);
        chk({tag, "_tc"}, tc, (m_cnt[ech][13:0] == 14'd0));
        pmode = m_cnt[ech][15:14];
        pend = 1;
        chn[ech]++;
        m_transfer(ech);
        ntr++;
        if (ntr == stop_after) drq = 4'b0000;
      end else if (dack == 0 && tc !== 1'b0) begin
        chk({tag, "_tc_idle"}, tc, 0);
      end
      if ($countones(dack) > 1) chk({tag, "_onehot"}, dack, 32'(1) << m_next_ch());
      pd = dack;
      if (!hrq && (drq & m_mode[3:0]) == 0 && !pend) done = 1;
    end
    chk({tag, "_finished"}, done, 1);
  endtask

  initial begin
    logic [15:0] ra, rc;
    logic [7:0]  md;
    logic [3:0]  en;
    logic        found;
    m_reset();
    #12;
    chk("rst_hrq", hrq, 0);
    chk("rst_dack", dack, 0);
    chk("rst_memr", memr_n, 1);
    chk("rst_memw", memw_n, 1);
    chk("rst_tc", tc, 0);
    reset_n = 1'b1;
    cpu_rd_chk(4'd8, "rst_status");

    cpu_wr(4'd0, 8'h34); cpu_wr(4'd0, 8'h12);
    cpu_rd_chk(4'd0, "readback_lo");
    cpu_rd_chk(4'd0, "readback_hi");
    chk("readback_model", m_addr[0], 16'h1234);

    hlda_en = 1'b1;
    cpu_wr(4'd8, 8'h04);
    prog_ch(2, 16'h7600, 16'h804F);
    drq = 4'b0100;
    run(80, "video");
    chk("video_ntr", ntr, 80);
    chk("video_memr_pulses", rd_low, 80);
    chk("video_memw_pulses", wr_low, 0);
    cpu_rd_chk(4'd8, "video_status");
    cpu_rd_chk(4'd8, "video_status_clr");

    cpu_wr(4'd8, 8'h84);
    prog_ch(2, 16'h7600, 16'h804F);
    drq = 4'b0100;
    run(80, "autoload");
    cpu_rd_chk(4'd4, "al_addr_lo");
    cpu_rd_chk(4'd4, "al_addr_hi");
    chk("al_model_addr", m_addr[2], 16'h7600);
    cpu_rd_chk(4'd8, "al_status");
    drq = 4'b0100;
    run(1, "al_next");
    cpu_rd_chk(4'd8, "al_status_after");

    cpu_wr(4'd8, 8'h05);
    prog_ch(0, 16'($urandom), 16'hBFFF);
    prog_ch(2, 16'($urandom), 16'h3FFF);
    drq = 4'b0101;
    run(6, "fixed");
    chk("fixed_ch2_served", chn[2], 0);
    cpu_wr(4'd8, 8'h15);
    drq = 4'b0101;
    run(6, "rotate");
    chk("rotate_ch0", chn[0], 3);
    chk("rotate_ch2", chn[2], 3);

    cpu_wr(4'd8, 8'h41);
    prog_ch(0, 16'($urandom), 16'h4002);
    drq = 4'b0001;
    run(0, "tcstop");
    chk("tcstop_ntr", ntr, 3);
    chk("tcstop_memw", wr_low, 3);
    repeat (3) @(negedge clk);
    chk("tcstop_hrq_low", hrq, 0);
    cpu_rd_chk(4'd8, "tcstop_status");
    drq = 4'b0000;

    for (int r = 0; r < 4; r++) begin
      en = 4'($urandom_range(1, 15));
      md = {1'($urandom), 1'($urandom), 1'b0, 1'($urandom), en};
      cpu_wr(4'd8, md);
      for (int ch = 0; ch < 4; ch++) begin
        ra = 16'($urandom);
        rc = {2'($urandom_range(0, 2)), 14'($urandom_range(0, 5))};
        prog_ch(ch, ra, rc);
      end
      drq = 4'($urandom_range(1, 15)) & en;
      if (drq == 0) drq = en;
      run(14, "rand");
      cpu_rd_chk(4'd8, "rand_status");
      cpu_rd_chk(4'd6, "rand_ch3_lo");
      drq = 4'b0000;
    end

    hlda_en = 1'b0;
    cpu_wr(4'd8, 8'h02);
    prog_ch(1, 16'($urandom), 16'h8005);
    drq = 4'b0010;
    repeat (3) @(negedge clk);
    chk("hs_hrq", hrq, 1);
    chk("hs_dack", dack, 0);
    repeat (4) @(negedge clk);
    chk("hs_hold_dack", dack, 0);
    drq = 4'b0000;
    repeat (2) @(negedge clk);
    chk("hs_drop_hrq", hrq, 0);

    hlda_en = 1'b1;
    drq = 4'b0010;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!memr_n) found = 1'b1;
    end
    chk("rst_reach_s2", found, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_hrq", hrq, 0);
    chk("arst_dack", dack, 0);
    chk("arst_memr", memr_n, 1);
    chk("arst_memw", memw_n, 1);
    chk("arst_tc", tc, 0);
    chk("arst_oaddr", oaddr, 0);
    drq = 4'b0000;
    m_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpu_rd_chk(4'd2, "arst_ch1_addr");
    cpu_rd_chk(4'd3, "arst_ch1_cnt");
    cpu_rd_chk(4'd8, "arst_status");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/k580vt57.md
Name: k580vt57

Overview:
- Four-channel DMA controller, functionally modelled on the K580VT57/8257.
- Sits directly upstream of the CRT controller: it answers the CRT's drq by taking the bus, addressing video RAM and pulsing dack while the memory drives the character onto ichar.
- Channel 2 is the video channel; its address/count auto-reload from channel 3 each frame.
- Also handles CPU register programming over the 8080 bus.

Parameters:
- NCH, 4, number of channels (fixed at 4 for register map; kept for readability).
- AUTOLOAD_CH, 2, channel reloaded from channel AUTOLOAD_CH+1 when autoload is enabled.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- iaddr  in  4  CPU register address.
- idata  in  8  CPU write data.
- odata  out  8  CPU read data (combinational from iaddr).
- iwe_n  in  1  CPU write strobe, active-low; a register write commits on its rising edge.
- ird_n  in  1  CPU read strobe, active-low; read side effects apply on its rising edge.
- drq  in  4  channel DMA requests, active-high.
- dack  out  4  channel acknowledges, one-hot, active-high.
- hrq  out  1  bus hold request to CPU.
- hlda  in  1  hold acknowledge from CPU.
- oaddr  out  16  memory address during transfer.
- memr_n  out  1  memory read strobe (read-mode transfers).
- memw_n  out  1  memory write strobe (write-mode transfers).
- tc  out  1  terminal count, high during the last transfer of a block.

Behaviour:
- Reset (async): all address, count and mode registers = 0. byte_ff = 0. hrq = 0. dack = 0. memr_n = memw_n = 1. tc = 0. Status = 0. State = IDLE.
- Register map, written via byte_ff (low byte then high byte), toggled per access:
  - iaddr even 0..6: channel n = iaddr[2:1] address.
  - iaddr odd 1..7: channel n count. Bits 13:0 = length−1; bits 15:14 = mode (01 write, 10 read, 00 verify).
  - iaddr 8, write: mode register. Bits 3:0 = channel enable; 4 = rotating priority; 6 = TC-stop; 7 = autoload. A write clears byte_ff.
  - iaddr 8, read: status. Bits 3:0 = TC flags; bit 4 = update flag. Reading clears bits 3:0.
  - Address/count reads return the current value, byte selected by byte_ff.
- Programming channel AUTOLOAD_CH writes both that channel and channel AUTOLOAD_CH+1 when autoload=1.
- FSM:
  - IDLE: if any (drq & enable) → HREQ, hrq=1.
  - HREQ: wait for hlda=1, then latch the winning channel → S1. If the request vanishes before hlda → IDLE with hrq=0.
  - S1: oaddr = channel address; dack[ch] = 1.
  - S2: memr_n=0 if mode=10, memw_n=0 if mode=01; dack held.
  - S3: strobes released; address += 1; count[13:0] −= 1 (14-bit wrap); dack held.
  - S4: dack = 0. If any (drq & enable) still set and hlda=1 → S1, else hrq=0 → IDLE.
  - One transfer = 4 clocks after grant. hlda dropping in any state completes the current S1..S4 and then returns to IDLE.
- Priority:
  - Fixed: ch0 highest.
  - Rotating: the channel last served becomes lowest, evaluated at HREQ→S1 and S4→S1.
- Terminal count: tc=1 in S1..S3 when count[13:0]==0 at S1. At S3, set the TC flag for that channel.
  - If TC-stop: clear that channel's enable bit.
  - If autoload and ch==AUTOLOAD_CH: copy ch3 address/count into ch2 at S3 and set update flag; ch2 stays enabled regardless of TC-stop.
- Update flag clears at the next ch2 transfer that is not TC.
- Simultaneous events:
  - A CPU write on the same clock as S3's register update: the CPU write wins for that register.
  - A mode write mid-transfer takes effect at the next arbitration.
  - Reset mid-transfer aborts immediately to reset values.

Decomposition:
- Package k580vt57_pkg:
  - state enum (IDLE, HREQ, S1, S2, S3, S4).
  - register-address constants (REG_MODE=8).
  - mode-bit indices and transfer-mode codes.
- Sub-module k580vt57_channel: one channel's address/count registers, byte-wise load, increment/decrement, TC detect and reload input. Instantiated 4 times; the top module holds FSM, arbiter and CPU interface.

Test Plan:
- Program ch2 addr=0x7600, count=0x804F, enable ch2; hold drq[2]=1, hlda tied to hrq one clock later → 80 transfers. Check oaddr 0x7600..0x764F, memr_n low once per transfer, tc only on the last, status bit2 set.
- Autoload: mode=0x84, ch2/ch3 programmed 0x7600/0x804F, run 80 transfers. Ch2 address returns to 0x7600, update flag=1, next request starts at 0x7600.
- Priority: drq=4'b0101 held. Fixed mode serves ch0 continuously. Rotating mode (bit4) alternates ch0/ch2; dack stays one-hot.
- TC-stop: mode=0x41, ch0 count=0x4002 → exactly 3 memw_n pulses, then enable bit0 clears and hrq drops despite drq[0] held.
- Handshake: drq asserted with hlda held low → hrq=1, no dack. Drop drq → hrq=0, IDLE. Assert reset_n=0 during S2 → all outputs at reset values asynchronously.
- Register readback: write 0x34,0x12 to iaddr 0 and read back 0x34,0x12. Read status twice: first returns TC flags, second returns 0.
